// File: rtl/delay_counter.sv
// delay_counter: start-gated one-shot microsecond delay timer.
// While start is held high the block counts CLK cycles through a two-stage
// counter (cycles-per-microsecond prescaler, then elapsed microseconds) and
// raises out once CLOCK_SPEED_MHZ * US_DELAY cycles have elapsed. Dropping
// start for a single cycle clears everything for the next use. A zero-length
// delay is clamped to one cycle.
module delay_counter #(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int US_DELAY        = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  output logic out
);

  // Reject parameter values the counter cannot represent.
  if (CLOCK_SPEED_MHZ < 1 || US_DELAY < 0) begin : g_bad_param
    $error("delay_counter: CLOCK_SPEED_MHZ must be >= 1 and US_DELAY >= 0");
  end

  // Counter widths, each at least one bit so a zero-width vector never appears.
  localparam int TICK_W_RAW = $clog2(CLOCK_SPEED_MHZ + 1);
  localparam int CNT_W_RAW  = $clog2(US_DELAY + 1);
  localparam int TICK_W     = (TICK_W_RAW < 1) ? 1 : TICK_W_RAW;
  localparam int CNT_W      = (CNT_W_RAW  < 1) ? 1 : CNT_W_RAW;

  // A zero-microsecond request still takes one cycle.
  localparam bit CLAMPED = (US_DELAY == 0);

  // Last prescaler value before it wraps back to zero.
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLOCK_SPEED_MHZ - 1);
  // Ceiling for the microsecond counter; it never advances past this.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(US_DELAY);
  // Microsecond count during the final microsecond of the delay.
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(CLAMPED ? 0 : US_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TICK_W-1:0] us_tick;
  logic [TICK_W-1:0] us_tick_nxt;
  logic [TICK_W-1:0] us_tick_adv;
  logic [CNT_W-1:0]  us_cnt;
  logic [CNT_W-1:0]  us_cnt_nxt;
  logic [CNT_W-1:0]  us_cnt_adv;
  logic              tick_wrap;
  logic              elapse_done;
  logic              out_nxt;

  // Counter advance: prescaler wraps each microsecond, us_cnt saturates.
  always_comb begin
    tick_wrap   = (us_tick == TICK_LAST);
    us_tick_adv = tick_wrap ? '0 : us_tick + TICK_W'(1);
    us_cnt_adv  = (tick_wrap && us_cnt != CNT_LAST) ? us_cnt + CNT_W'(1) : us_cnt;
    // The advance being applied on this edge is the one that completes cycle N.
    elapse_done = CLAMPED || (tick_wrap && us_cnt == CNT_PRE);
  end

  // Next-state and next-counter selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt   = state;
    us_tick_nxt = us_tick;
    us_cnt_nxt  = us_cnt;

    if (!start) begin
      state_nxt   = S_IDLE;
      us_tick_nxt = '0;
      us_cnt_nxt  = '0;
    end else begin
      unique case (state)
        // From IDLE the counters are zero, so the first advance is cycle 1.
        S_IDLE, S_COUNT: begin
          us_tick_nxt = us_tick_adv;
          us_cnt_nxt  = us_cnt_adv;
          state_nxt   = elapse_done ? S_DONE : S_COUNT;
        end
        // Saturate: hold counters and flag until start drops.
        S_DONE: begin
          state_nxt = S_DONE;
        end
        default: begin
          state_nxt   = S_IDLE;
          us_tick_nxt = '0;
          us_cnt_nxt  = '0;
        end
      endcase
    end

    out_nxt = (state_nxt == S_DONE);
  end

  // State, counters and the registered done flag; RESET overrides start.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (RESET) begin
      state   <= S_IDLE;
      us_tick <= '0;
      us_cnt  <= '0;
      out     <= 1'b0;
    end else begin
      state   <= state_nxt;
      us_tick <= us_tick_nxt;
      us_cnt  <= us_cnt_nxt;
      out     <= out_nxt;
    end
  end

endmodule

// File: tb/tb_delay_counter.sv
// Directed bench for delay_counter: default instance (12 MHz, 2 us, N = 24)
// plus a parameter sweep of four further instances sharing one clock.
module tb_delay_counter;

  logic CLK;
  logic RESET;
  logic start;
  logic out;

  logic sw_reset;
  logic sw_start;
  logic out_1_1;
  logic out_1_0;
  logic out_12_120;
  logic out_48_3;

  int vectors;
  int miscompares;

  delay_counter #(.CLOCK_SPEED_MHZ(12), .US_DELAY(2)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .out(out)
  );

  delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(1)) dut_1_1 (
    .CLK(CLK), .RESET(sw_reset), .start(sw_start), .out(out_1_1)
  );

  delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(0)) dut_1_0 (
    .CLK(CLK), .RESET(sw_reset), .start(sw_start), .out(out_1_0)
  );

  delay_counter #(.CLOCK_SPEED_MHZ(12), .US_DELAY(120)) dut_12_120 (
    .CLK(CLK), .RESET(sw_reset), .start(sw_start), .out(out_12_120)
  );

  delay_counter #(.CLOCK_SPEED_MHZ(48), .US_DELAY(3)) dut_48_3 (
    .CLK(CLK), .RESET(sw_reset), .start(sw_start), .out(out_48_3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One sample: wait for the edge, then settle so outputs are stable and
  // newly driven inputs apply to the next edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    start = 1'b1;
    step();
    vectors++;
    if (out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got %b want 0", out);
    end
    vectors++;
    if (dut.us_tick !== 4'd0 || dut.us_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got tick=%0d cnt=%0d want 0/0", dut.us_tick, dut.us_cnt);
    end
    RESET = 1'b0;
    start = 1'b0;
    step();
    vectors++;
    if (out !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_out: got %b want 0", out);
    end
  endtask

  // Case 1: start held from edge 0; out low through edge 22, high from 23.
  task automatic test_default_delay();
    start = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      step();
      vectors++;
      if (out !== 1'b0) begin
        miscompares++;
        $display("FAIL default_early edge %0d: got %b want 0", e, out);
      end
    end
    step();
    vectors++;
    if (out !== 1'b1) begin
      miscompares++;
      $display("FAIL default_rise edge 23: got %b want 1", out);
    end
    for (int e = 0; e < 100; e++) begin
      step();
      vectors++;
      if (out !== 1'b1) begin
        miscompares++;
        $display("FAIL default_hold cycle %0d: got %b want 1", e, out);
      end
    end
    // 24 elapsed cycles = 2 full microseconds, prescaler back at 0, frozen.
    vectors++;
    if (dut.us_tick !== 4'd0 || dut.us_cnt !== 2'd2) begin
      miscompares++;
      $display("FAIL done_saturate: got tick=%0d cnt=%0d want 0/2", dut.us_tick, dut.us_cnt);
    end
  endtask

  // Case 2: one low cycle clears, then a fresh 24-sample delay.
  task automatic test_clear_restart();
    start = 1'b0;
    step();
    vectors++;
    if (out !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_fall: got %b want 0", out);
    end
    start = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      vectors++;
      if (out !== (i == 24)) begin
        miscompares++;
        $display("FAIL restart sample %0d: got %b want %b", i, out, (i == 24));
      end
    end
  endtask

  // Case 3: abandon after 20 samples, low for 3, restart from scratch.
  task automatic test_abort();
    start = 1'b0;
    step();
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      vectors++;
      if (out !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_run sample %0d: got %b want 0", i, out);
      end
    end
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (out !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_low sample %0d: got %b want 0", i, out);
      end
    end
    start = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      vectors++;
      if (out !== (i == 24)) begin
        miscompares++;
        $display("FAIL abort_rerun sample %0d: got %b want %b", i, out, (i == 24));
      end
    end
  endtask

  // start falls on the sample that would have completed the count.
  task automatic test_fall_at_completion();
    start = 1'b0;
    step();
    start = 1'b1;
    for (int i = 1; i <= 23; i++) step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++;
      if (out !== 1'b0) begin
        miscompares++;
        $display("FAIL fall_at_done sample %0d: got %b want 0", i, out);
      end
    end
  endtask

  // Case 4: reset at sample 10 mid-count, then reset while in DONE.
  task automatic test_reset_mid_count();
    start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    RESET = 1'b1;
    step();
    vectors++;
    if (out !== 1'b0 || dut.us_tick !== 4'd0 || dut.us_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL midcount_reset: got out=%b tick=%0d cnt=%0d want 0/0/0",
               out, dut.us_tick, dut.us_cnt);
    end
    RESET = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      vectors++;
      if (out !== (i == 24)) begin
        miscompares++;
        $display("FAIL post_reset sample %0d: got %b want %b", i, out, (i == 24));
      end
    end
    RESET = 1'b1;
    step();
    vectors++;
    if (out !== 1'b0) begin
      miscompares++;
      $display("FAIL done_reset: got %b want 0", out);
    end
    RESET = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      vectors++;
      if (out !== (i == 24)) begin
        miscompares++;
        $display("FAIL done_reset_rerun sample %0d: got %b want %b", i, out, (i == 24));
      end
    end
  endtask

  // Case 6: RESET and start together for 5 cycles; reset wins throughout.
  task automatic test_priority();
    start = 1'b1;
    RESET = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++;
      if (out !== 1'b0 || dut.us_tick !== 4'd0) begin
        miscompares++;
        $display("FAIL priority cycle %0d: got out=%b tick=%0d want 0/0", i, out, dut.us_tick);
      end
    end
    RESET = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      vectors++;
      if (out !== (i == 24)) begin
        miscompares++;
        $display("FAIL priority_release sample %0d: got %b want %b", i, out, (i == 24));
      end
    end
  endtask

  // Case 5: record the first sample each sweep instance goes high, and
  // confirm it never drops while start stays high.
  task automatic test_param_sweep();
    int rise_1_1;
    int rise_1_0;
    int rise_12_120;
    int rise_48_3;
    int drops;
    rise_1_1    = 0;
    rise_1_0    = 0;
    rise_12_120 = 0;
    rise_48_3   = 0;
    drops       = 0;
    sw_reset = 1'b1;
    sw_start = 1'b0;
    step();
    sw_reset = 1'b0;
    vectors++;
    if ({out_1_1, out_1_0, out_12_120, out_48_3} !== 4'b0000) begin
      miscompares++;
      $display("FAIL sweep_reset: got %b want 0000", {out_1_1, out_1_0, out_12_120, out_48_3});
    end
    sw_start = 1'b1;
    for (int i = 1; i <= 1500; i++) begin
      step();
      if (out_1_1)    begin if (rise_1_1 == 0)    rise_1_1 = i;    end else if (rise_1_1 != 0)    drops++;
      if (out_1_0)    begin if (rise_1_0 == 0)    rise_1_0 = i;    end else if (rise_1_0 != 0)    drops++;
      if (out_12_120) begin if (rise_12_120 == 0) rise_12_120 = i; end else if (rise_12_120 != 0) drops++;
      if (out_48_3)   begin if (rise_48_3 == 0)   rise_48_3 = i;   end else if (rise_48_3 != 0)   drops++;
    end
    vectors++;
    if (rise_1_1 !== 1) begin
      miscompares++;
      $display("FAIL sweep_1_1 latency: got %0d want 1", rise_1_1);
    end
    vectors++;
    if (rise_1_0 !== 1) begin
      miscompares++;
      $display("FAIL sweep_1_0 latency: got %0d want 1", rise_1_0);
    end
    vectors++;
    if (rise_12_120 !== 1440) begin
      miscompares++;
      $display("FAIL sweep_12_120 latency: got %0d want 1440", rise_12_120);
    end
    vectors++;
    if (rise_48_3 !== 144) begin
      miscompares++;
      $display("FAIL sweep_48_3 latency: got %0d want 144", rise_48_3);
    end
    vectors++;
    if (drops !== 0) begin
      miscompares++;
      $display("FAIL sweep_sticky: got %0d drops want 0", drops);
    end
    sw_start = 1'b0;
    step();
    vectors++;
    if ({out_1_1, out_1_0, out_12_120, out_48_3} !== 4'b0000) begin
      miscompares++;
      $display("FAIL sweep_clear: got %b want 0000", {out_1_1, out_1_0, out_12_120, out_48_3});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET       = 1'b1;
    start       = 1'b0;
    sw_reset    = 1'b1;
    sw_start    = 1'b0;

    test_reset();
    test_default_delay();
    test_clear_restart();
    test_abort();
    test_fall_at_completion();
    test_reset_mid_count();
    test_priority();
    test_param_sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
